// File: rtl/track_section_if.sv
// ----------------------------------------------------------------------------
// Interface : track_section_if
// Purpose   : Sensor and actuator bundle between the train-track controller
//             side (master) and the track_section_arbiter (slave).
// Signals   : req_a, req_b  train A/B waiting at the section entry sensor
//             occupied      section occupancy sensor, 1 = train inside
//             gnt_a, gnt_b  section granted to A/B
//             sw_sel        section switch, 0 = route A, 1 = route B
//             da, db        train drive codes, 2'b00 stop, 2'b01 forward
//             fault         sticky timeout fault
// Revision  : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface track_section_if;
  logic       req_a;
  logic       req_b;
  logic       occupied;
  logic       gnt_a;
  logic       gnt_b;
  logic       sw_sel;
  logic [1:0] da;
  logic [1:0] db;
  logic       fault;

  modport master (
    output req_a, req_b, occupied,
    input  gnt_a, gnt_b, sw_sel, da, db, fault
  );

  modport slave (
    input  req_a, req_b, occupied,
    output gnt_a, gnt_b, sw_sel, da, db, fault
  );
endinterface

`default_nettype wire

// File: rtl/track_section_arbiter.sv
// ----------------------------------------------------------------------------
// Module    : track_section_arbiter
// Purpose   : Arbitrates one shared single-line track section between train A
//             and train B. Sequence: grant -> switch settle -> drive ->
//             occupancy clear -> guard. Round-robin when both trains wait.
// Ports     : clk   single clock, all logic on posedge
//             rst   synchronous active-high reset
//             sec   track_section_if.slave (requests, occupancy, grants,
//                   switch select, drive codes, fault)
// Config    : TRACK_TIMEOUT_EN - when defined, a GO/BUSY watchdog moves the
//             arbiter into a sticky FAULT state after TIMEOUT_CYCLES cycles.
//             When undefined, GO/BUSY wait forever and fault is tied 0.
// Revision  : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module track_section_arbiter #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int GUARD_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  track_section_if.slave   sec
);

  // Reject unusable configurations at elaboration time.
  if (SETTLE_CYCLES < 1 || GUARD_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CNT_W < 1)
  begin : g_param_check
    $error("track_section_arbiter: cycle parameters and CNT_W must be >= 1");
  end

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_GO    = 3'd2;
  localparam logic [2:0] ST_BUSY  = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;
`ifdef TRACK_TIMEOUT_EN
  localparam logic [2:0] ST_FAULT = 3'd5;
`endif

  localparam logic [1:0] DRV_STOP = 2'b00;
  localparam logic [1:0] DRV_FWD  = 2'b01;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             sw_sel_q, sw_sel_d;
  logic [1:0]       da_q, da_d;
  logic [1:0]       db_q, db_d;
  // 1 = B wins the next tie (A was served last); reset leaves A first.
  logic             prio_b_q, prio_b_d;
  logic             pick_b;
  logic             gnt_req;

  // Saturating increment: counter parks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Request line of whichever side currently holds the grant.
  assign gnt_req = sw_sel_q ? sec.req_b : sec.req_a;

  // On a tie the side not served last wins.
  assign pick_b = sec.req_b && (!sec.req_a || prio_b_q);

`ifdef TRACK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             fault_q, fault_d;
  logic             in_drive;

  assign in_drive = (state_q == ST_GO) || (state_q == ST_BUSY);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_a_d  = gnt_a_q;
    gnt_b_d  = gnt_b_q;
    sw_sel_d = sw_sel_q;
    da_d     = da_q;
    db_d     = db_q;
    prio_b_d = prio_b_q;
`ifdef TRACK_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    fault_d  = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // An occupied section in IDLE means an intruder: never grant.
        if (!sec.occupied && (sec.req_a || sec.req_b)) begin
          state_d  = ST_SETUP;
          gnt_a_d  = !pick_b;
          gnt_b_d  = pick_b;
          sw_sel_d = pick_b;
          cnt_d    = '0;
        end
      end

      ST_SETUP: begin
        // Abort has priority over finishing the settle window.
        if (!gnt_req) begin
          state_d = ST_IDLE;
          gnt_a_d = 1'b0;
          gnt_b_d = 1'b0;
          da_d    = DRV_STOP;
          db_d    = DRV_STOP;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_GO;
          if (sw_sel_q) db_d = DRV_FWD;
          else          da_d = DRV_FWD;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_GO: begin
        if (sec.occupied) state_d = ST_BUSY;
      end

      ST_BUSY: begin
        if (!sec.occupied) begin
          state_d  = ST_CLEAR;
          gnt_a_d  = 1'b0;
          gnt_b_d  = 1'b0;
          da_d     = DRV_STOP;
          db_d     = DRV_STOP;
          prio_b_d = !sw_sel_q;
          cnt_d    = '0;
        end
      end

      ST_CLEAR: begin
        if (cnt_q == GUARD_LAST) state_d = ST_IDLE;
        else                     cnt_d   = cnt_inc;
      end

`ifdef TRACK_TIMEOUT_EN
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
`endif

      default: begin
        state_d = ST_IDLE;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        da_d    = DRV_STOP;
        db_d    = DRV_STOP;
      end
    endcase

`ifdef TRACK_TIMEOUT_EN
    // Watchdog over GO+BUSY. Only leaving via CLEAR counts as an exit, so a
    // section that clears on the expiry cycle still completes normally.
    if (state_q == ST_SETUP && state_d == ST_GO) begin
      to_cnt_d = '0;
    end else if (in_drive) begin
      to_cnt_d = (&to_cnt_q) ? to_cnt_q : to_cnt_q + 1'b1;
      if (to_cnt_q == TIMEOUT_LAST && state_d != ST_CLEAR) begin
        state_d = ST_FAULT;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        da_d    = DRV_STOP;
        db_d    = DRV_STOP;
        fault_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      sw_sel_q <= 1'b0;
      da_q     <= DRV_STOP;
      db_q     <= DRV_STOP;
      prio_b_q <= 1'b0;
`ifdef TRACK_TIMEOUT_EN
      to_cnt_q <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      sw_sel_q <= sw_sel_d;
      da_q     <= da_d;
      db_q     <= db_d;
      prio_b_q <= prio_b_d;
`ifdef TRACK_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      fault_q  <= fault_d;
`endif
    end
  end

  assign sec.gnt_a  = gnt_a_q;
  assign sec.gnt_b  = gnt_b_q;
  assign sec.sw_sel = sw_sel_q;
  assign sec.da     = da_q;
  assign sec.db     = db_q;
`ifdef TRACK_TIMEOUT_EN
  assign sec.fault  = fault_q;
`else
  assign sec.fault  = 1'b0;
`endif

endmodule

`default_nettype wire
